serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial multi-bit adder controller that shares one 1-bit full-add cell across cycles. The cell is built from two `Half_Adder` cells plus an OR for carry-out. On a Start pulse it latches two WIDTH-bit operands and sequences the shared cell LSB-first, one bit per clock, with a registered carry. It then presents the WIDTH-bit Sum and the final carry with a one-cycle Done pulse. It trades area for latency in the arithmetic layer above the team's gate-level adder cells.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op_A  input  WIDTH  operand A; sampled with an accepted Start.
- Op_B  input  WIDTH  operand B; sampled with an accepted Start.
- Sub  input  1  subtract mode; sampled with an accepted Start. Present only with SERIAL_ADDER_SUB_EN.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse in DONE; Sum and Carry_Out are valid.
- Sum  output  WIDTH  result; registered, holds its value until the next completion.
- Carry_Out  output  1  final carry; registered, updates together with Sum.

## Operation
- Reset value of every output: Busy=0, Done=0, Sum=0, Carry_Out=0.
- Reset value of internal state: state=IDLE, counter=0, carry register=0, shift registers=0.
- Rst is asynchronous and wins over everything, including mid-RUN; the partial result is discarded.
- IDLE: on Start=1, latch Op_A and Op_B into the A/B shift registers, clear the counter, set carry register=0 (see Configuration), and go to RUN.
- IDLE with Start=0: all state holds.
- RUN (one bit per cycle):
  - bit = a[0]^b[0]^c;
  - c_next = (a[0]&b[0]) | (c&(a[0]^b[0]));
  - shift A and B right by one; shift the bit into the MSB of the result shift register;
  - counter increments.
- RUN exit: on the cycle where counter==WIDTH-1, the same edge loads Sum from the completed result and Carry_Out from c_next, then goes to DONE.
- DONE: Done=1 for exactly one cycle, then unconditionally IDLE.
- Start while Busy=1 (RUN or DONE) is ignored, not queued.
- Counter width is $clog2(WIDTH); the counter never wraps past WIDTH-1 within RUN.
- Sum and Carry_Out never change except at the completion edge or on reset. No partial results are visible.
- Arithmetic is unsigned modulo 2^WIDTH; Carry_Out is bit WIDTH of the true sum.

## Timing
- Start accepted at edge E0.
- Bit i is computed at edge E(i+1).
- Sum/Carry_Out update at edge E(WIDTH).
- Done is high in the cycle after E(WIDTH), i.e. latency from accept to Done is WIDTH cycles.
- Busy rises after E0 and falls after E(WIDTH+1).
- Earliest next accepted Start: the edge after the Done cycle, giving a throughput of one operation per WIDTH+2 cycles.
- Op_A, Op_B and Sub may change freely after E0.

## Configuration
- SERIAL_ADDER_SUB_EN defined: Sub port exists.
  - Sub=1 at accept: the B shift register loads ~Op_B and the carry register initialises to 1.
  - The result is A-B mod 2^WIDTH; Carry_Out=1 means no borrow (A>=B unsigned).
  - Sub=0 behaves as addition.
- SERIAL_ADDER_SUB_EN undefined: no Sub port; carry always initialises to 0; add only.

## Test plan
- Rst asserted asynchronously between edges -> all outputs 0 immediately, without waiting for Clk.
- WIDTH=8, Op_A=0x5A, Op_B=0x3C, Start for one cycle -> Done exactly 8 cycles after accept, Sum=0x96, Carry_Out=0; Busy high for 9 cycles.
- Op_A=0xFF, Op_B=0x01 -> Sum=0x00, Carry_Out=1. Then Op_A=0x00, Op_B=0x00 -> Sum=0x00, Carry_Out=0.
- Start held high continuously with new operands applied mid-RUN -> the first result uses the operands latched at accept. The next operation is accepted on the edge after the Done cycle; no accept in RUN or DONE.
- Rst pulsed at the 4th RUN cycle of 0x5A+0x3C -> Sum=0, Busy=0, no Done. A following 0x11+0x22 -> Sum=0x33, Carry_Out=0.
- With SERIAL_ADDER_SUB_EN:
  - 0x10-0x01 -> Sum=0x0F, Carry_Out=1;
  - 0x01-0x02 -> Sum=0xFF, Carry_Out=0;
  - Sub=0 with 0x5A+0x3C -> Sum=0x96.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that reuses one full-add cell (two half adders + OR), LSB first.
// Optional subtract mode and Sub port are enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Op_A,
    input  logic [WIDTH-1:0] Op_B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_Out
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic s;
        logic c;
    } ha_t;

    function automatic ha_t half_add(input logic x, input logic y);
        ha_t r;
        r.s = x ^ y;
        r.c = x & y;
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic sub_sel;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = Sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Shared 1-bit full-add cell: two half adders, carry-out is the OR of both half-adder carries.
    ha_t  ha0, ha1;
    logic fa_sum, fa_cout;
    assign ha0     = half_add(a_q[0], b_q[0]);
    assign ha1     = half_add(ha0.s, carry_q);
    assign fa_sum  = ha1.s;
    assign fa_cout = ha0.c | ha1.c;

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = Op_A;
                    b_d     = sub_sel ? ~Op_B : Op_B;
                    carry_d = sub_sel;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (cnt_q == LAST) begin
                    // Outputs only ever see the completed word, never a partial one.
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are reset along with the FSM so a reset mid-RUN leaves no stale bits behind.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Sum       = sum_q;
    assign Carry_Out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): latency, Busy window, held Start, async reset, optional subtract.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             Clk    = 1'b0;
    logic             Rst    = 1'b1;
    logic             Start  = 1'b0;
    logic             sub_in = 1'b0;
    logic [WIDTH-1:0] Op_A   = '0;
    logic [WIDTH-1:0] Op_B   = '0;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Carry_Out;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_sum  = '0;
    logic             exp_cout = 1'b0;

    always #5 Clk = ~Clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op_A      (Op_A),
        .Op_B      (Op_B),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub       (sub_in),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Sum       (Sum),
        .Carry_Out (Carry_Out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        Start  = 1'b1;
        Op_A   = a;
        Op_B   = b;
        sub_in = s;
    endtask

    // Called at the negedge just before the accepting edge; returns at the negedge after Busy should have fallen.
    task automatic finish_op(input string tag, input logic [WIDTH-1:0] es, input logic ec, input bit hold);
        int k;
        bit done_seen;
        k = 1;
        done_seen = 0;
        @(negedge Clk);
        if (!hold) Start = 1'b0;
        Op_A   = ~Op_A;
        Op_B   = ~Op_B;
        sub_in = ~sub_in;
        while (!done_seen && k <= 4 * WIDTH) begin
            if (Done) begin
                done_seen = 1;
            end else begin
                check({tag, "_busy_run"}, {31'b0, Busy}, 32'd1);
                check({tag, "_no_partial"}, {23'b0, Carry_Out, Sum}, {23'b0, exp_cout, exp_sum});
                @(negedge Clk);
                k++;
            end
        end
        check({tag, "_done_seen"}, {31'b0, done_seen}, 32'd1);
        check({tag, "_latency"}, k - 1, WIDTH);
        check({tag, "_busy_done"}, {31'b0, Busy}, 32'd1);
        check({tag, "_sum"}, {24'b0, Sum}, {24'b0, es});
        check({tag, "_cout"}, {31'b0, Carry_Out}, {31'b0, ec});
        exp_sum  = es;
        exp_cout = ec;
        @(negedge Clk);
        check({tag, "_busy_fall"}, {31'b0, Busy}, 32'd0);
        check({tag, "_done_pulse"}, {31'b0, Done}, 32'd0);
        check({tag, "_sum_hold"}, {23'b0, Carry_Out, Sum}, {23'b0, exp_cout, exp_sum});
    endtask

    initial begin
        // Reset is asserted from time 0; outputs must be cleared before any clock edge.
        #2;
        check("por_busy", {31'b0, Busy}, 32'd0);
        check("por_done", {31'b0, Done}, 32'd0);
        check("por_sum", {24'b0, Sum}, 32'd0);
        check("por_cout", {31'b0, Carry_Out}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("idle_busy", {31'b0, Busy}, 32'd0);

        @(negedge Clk); launch(8'h5A, 8'h3C, 1'b0); finish_op("add_5a_3c", 8'h96, 1'b0, 0);
        @(negedge Clk); launch(8'hFF, 8'h01, 1'b0); finish_op("add_ff_01", 8'h00, 1'b1, 0);
        @(negedge Clk); launch(8'h00, 8'h00, 1'b0); finish_op("add_00_00", 8'h00, 1'b0, 0);

        // Start held high throughout: operands are scrambled mid-RUN, next accept only after the Done cycle.
        @(negedge Clk); launch(8'h12, 8'h34, 1'b0); finish_op("held_first", 8'h46, 1'b0, 1);
        launch(8'h21, 8'h43, 1'b0);                 finish_op("held_second", 8'h64, 1'b0, 0);

        @(negedge Clk); launch(8'h80, 8'h81, 1'b0); finish_op("add_80_81", 8'h01, 1'b1, 0);

        // Asynchronous reset between edges during the 4th RUN cycle of 0x5A+0x3C.
        @(negedge Clk); launch(8'h5A, 8'h3C, 1'b0);
        @(negedge Clk); Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("pre_rst_busy", {31'b0, Busy}, 32'd1);
        #2 Rst = 1'b1;
        #1;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_sum", {24'b0, Sum}, 32'd0);
        check("rst_cout", {31'b0, Carry_Out}, 32'd0);
        #1 Rst = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge Clk);
            check("post_rst_quiet", {21'b0, Busy, Done, Carry_Out, Sum}, 32'd0);
        end
        @(negedge Clk); launch(8'h11, 8'h22, 1'b0); finish_op("add_11_22", 8'h33, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        @(negedge Clk); launch(8'h10, 8'h01, 1'b1); finish_op("sub_10_01", 8'h0F, 1'b1, 0);
        @(negedge Clk); launch(8'h01, 8'h02, 1'b1); finish_op("sub_01_02", 8'hFF, 1'b0, 0);
        @(negedge Clk); launch(8'h5A, 8'h3C, 1'b0); finish_op("sub0_5a_3c", 8'h96, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
